// File: rtl/fifo_loader_pkg.sv
// Shared state encoding and counter sizing for the fifo_set loader.
package fifo_loader_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_LOAD,
        ST_DRAIN
    } loader_state_e;

    localparam int DEF_BITS        = 64;
    localparam int DEF_INPUT_DEPTH = 8;
    localparam int DEF_DEPTH       = 8;

    // A depth of 1 still needs a one-bit counter so the vectors stay legal.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FILL_CNT_W  = cntWidth(DEF_INPUT_DEPTH);
    localparam int SHIFT_CNT_W = cntWidth(DEF_DEPTH);

endpackage

// File: rtl/fifo_set_loader.sv
// Stages INPUT_DEPTH stream words, parallel-loads them into a fifo_set, then
// shifts the set out; the next set fills while the current one drains.
module fifo_set_loader
    import fifo_loader_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int INPUT_DEPTH = DEF_INPUT_DEPTH,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [BITS-1:0]                   in_data,
    output logic                              in_ready,
    output logic [INPUT_DEPTH-1:0][BITS-1:0]  out_array,
    output logic                              wr_en,
    output logic                              shift_en,
    output logic [BITS-1:0]                   shift_d,
    output logic                              busy,
    output logic                              done
);

    localparam int FILL_W  = cntWidth(INPUT_DEPTH);
    localparam int SHIFT_W = cntWidth(DEPTH);

    loader_state_e                   r_state;
    logic [FILL_W-1:0]               r_fillCnt;
    logic [SHIFT_W-1:0]              r_shiftCnt;
    logic                            r_full;
    logic [INPUT_DEPTH-1:0][BITS-1:0] r_staging;

    logic w_accept;
    logic w_lastWord;
    logic w_lastShift;
    logic w_setFull;

    assign in_ready    = !r_full && (r_state != ST_LOAD) && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_lastWord  = (r_fillCnt == FILL_W'(INPUT_DEPTH - 1));
    assign w_lastShift = (r_shiftCnt == SHIFT_W'(DEPTH - 1));
    // A set completing this cycle counts as staged so LOAD follows without a bubble.
    assign w_setFull   = r_full || (w_accept && w_lastWord);

    // Staging survives flush on purpose; only the bookkeeping is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging <= '0;
        end else if (w_accept) begin
            r_staging[r_fillCnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_fillCnt  <= '0;
            r_shiftCnt <= '0;
            r_full     <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_FILL;
            r_fillCnt  <= '0;
            r_shiftCnt <= '0;
            r_full     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_lastWord) begin
                    r_full    <= 1'b1;
                    r_fillCnt <= '0;
                end else begin
                    r_fillCnt <= r_fillCnt + FILL_W'(1);
                end
            end
            case (r_state)
                ST_FILL: begin
                    if (w_setFull) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_full     <= 1'b0;
                    r_shiftCnt <= '0;
                    r_state    <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_lastShift) begin
                        r_shiftCnt <= '0;
                        r_state    <= w_setFull ? ST_LOAD : ST_FILL;
                    end else begin
                        r_shiftCnt <= r_shiftCnt + SHIFT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign out_array = r_staging;
    assign wr_en     = (r_state == ST_LOAD);
    assign shift_en  = (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DRAIN) && w_lastShift;
    assign shift_d   = '0;
    assign busy      = (r_state != ST_FILL) || r_full || (r_fillCnt != '0);

endmodule

// File: tb/tb_fifo_set_loader.sv
// Self-checking bench for fifo_set_loader with a behavioural fifo_set model
// downstream and a word scoreboard from handshake to shifted output.
module tb_fifo_set_loader;

    localparam int BITS        = 64;
    localparam int INPUT_DEPTH = 8;
    localparam int DEPTH       = 8;

    typedef struct {
        logic            inValid;
        logic [BITS-1:0] inData;
        logic            expInReady;
        logic            expWrEn;
        logic            expShiftEn;
        logic            expDone;
        logic            expBusy;
    } vec_t;

    logic                              clk;
    logic                              rst_n;
    logic                              flush;
    logic                              in_valid;
    logic [BITS-1:0]                   in_data;
    logic                              in_ready;
    logic [INPUT_DEPTH-1:0][BITS-1:0]  out_array;
    logic                              wr_en;
    logic                              shift_en;
    logic [BITS-1:0]                   shift_d;
    logic                              busy;
    logic                              done;

    int errCnt = 0;
    int checkCnt = 0;
    int cycleCnt = 0;
    int shiftSeen = 0;
    int shiftTotal = 0;
    int wrEnCycles[$];
    int doneCycles[$];
    logic [BITS-1:0] sbQ[$];
    logic [BITS-1:0] fifoMem[DEPTH];

    fifo_set_loader #(
        .BITS(BITS),
        .INPUT_DEPTH(INPUT_DEPTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_array(out_array),
        .wr_en(wr_en),
        .shift_en(shift_en),
        .shift_d(shift_d),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [BITS-1:0] actual,
                               input logic [BITS-1:0] expected);
        checkCnt++;
        if (actual !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Downstream fifo_set model plus scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbQ.delete();
            for (int k = 0; k < DEPTH; k++) fifoMem[k] = '0;
            shiftSeen = 0;
        end else begin
            cycleCnt++;
            if (wr_en && shift_en) checkOutput("wr_en/shift_en exclusive", 1, 0);
            if (wr_en) begin
                checkOutput("staged set size", 64'(sbQ.size() >= INPUT_DEPTH), 1);
                for (int k = 0; k < INPUT_DEPTH; k++) begin
                    if (k < sbQ.size())
                        checkOutput($sformatf("out_array[%0d]", k), out_array[k], sbQ[k]);
                    fifoMem[k] = out_array[k];
                end
                shiftSeen = 0;
                wrEnCycles.push_back(cycleCnt);
            end
            if (shift_en) begin
                if (sbQ.size() == 0) begin
                    checkOutput("scoreboard underflow", fifoMem[0], {BITS{1'bx}});
                end else begin
                    checkOutput($sformatf("q shift %0d", shiftSeen), fifoMem[0], sbQ.pop_front());
                end
                checkOutput($sformatf("done at shift %0d", shiftSeen), 64'(done),
                            64'(shiftSeen == DEPTH - 1));
                for (int k = 0; k < DEPTH - 1; k++) fifoMem[k] = fifoMem[k+1];
                fifoMem[DEPTH-1] = shift_d;
                shiftSeen++;
                shiftTotal++;
                if (done) doneCycles.push_back(cycleCnt);
            end else if (done) begin
                checkOutput("done without shift_en", 64'(done), 0);
            end
            if (in_valid && in_ready) sbQ.push_back(in_data);
            if (flush) begin
                sbQ.delete();
                shiftSeen = 0;
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int row);
        in_valid = v.inValid;
        in_data  = v.inData;
        @(negedge clk);
        checkOutput($sformatf("row%0d in_ready", row), 64'(in_ready), 64'(v.expInReady));
        checkOutput($sformatf("row%0d wr_en", row), 64'(wr_en), 64'(v.expWrEn));
        checkOutput($sformatf("row%0d shift_en", row), 64'(shift_en), 64'(v.expShiftEn));
        checkOutput($sformatf("row%0d done", row), 64'(done), 64'(v.expDone));
        checkOutput($sformatf("row%0d busy", row), 64'(busy), 64'(v.expBusy));
        @(posedge clk); #1;
    endtask

    task automatic sendWord(input logic [BITS-1:0] w, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("in_ready wait bound", 64'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDoneCount(input int n);
        int cyc = 0;
        while (doneCycles.size() < n && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("done count reached", 64'(doneCycles.size()), 64'(n));
    endtask

    task automatic checkDrained(input string tag);
        logic anySet;
        anySet = 1'b0;
        for (int k = 0; k < DEPTH; k++) anySet = anySet | (|fifoMem[k]);
        checkOutput({tag, " fifo_set zero"}, 64'(anySet), 0);
        checkOutput({tag, " scoreboard empty"}, 64'(sbQ.size()), 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int waited;
        int waitSum;
        int shiftMark;
        int doneMark;

        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Table for a single back-to-back set through load and drain.
        for (int r = 0; r < 19; r++) begin
            v.inValid    = (r < 8);
            v.inData     = (r < 8) ? BITS'(r + 1) : '0;
            v.expInReady = (r != 8);
            v.expWrEn    = (r == 8);
            v.expShiftEn = (r >= 9 && r <= 16);
            v.expDone    = (r == 16);
            v.expBusy    = (r >= 1 && r <= 16);
            vecs.push_back(v);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 64'(in_ready), 1);
        checkOutput("reset wr_en", 64'(wr_en), 0);
        checkOutput("reset shift_en", 64'(shift_en), 0);
        checkOutput("reset done", 64'(done), 0);
        checkOutput("reset busy", 64'(busy), 0);
        checkOutput("reset out_array", 64'(out_array != '0), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], i);
        checkDrained("single");

        $display("[TB] overlapped sets");
        wrEnCycles.delete();
        doneCycles.delete();
        waitSum = 0;
        for (int i = 1; i <= 16; i++) begin
            sendWord(BITS'(i), waited);
            waitSum += waited;
        end
        in_valid = 1'b0;
        checkOutput("overlap in_ready low cycles", 64'(waitSum), 1);
        waitDoneCount(2);
        checkOutput("overlap wr_en count", 64'(wrEnCycles.size()), 2);
        if (wrEnCycles.size() == 2 && doneCycles.size() == 2) begin
            checkOutput("overlap reload gap", 64'(wrEnCycles[1] - doneCycles[0]), 1);
            checkOutput("overlap drain length", 64'(doneCycles[1] - wrEnCycles[1]), DEPTH);
        end
        idle(2);
        checkDrained("overlap");

        $display("[TB] gaps and backpressure");
        doneCycles.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0;
            in_data  = 64'hBAD;
            @(negedge clk);
            if (i > 0) checkOutput("gap busy", 64'(busy), 1);
            @(posedge clk); #1;
            sendWord(BITS'(64'h41 + i), waited);
        end
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        @(negedge clk);
        checkOutput("load in_ready", 64'(in_ready), 0);
        checkOutput("load wr_en", 64'(wr_en), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitDoneCount(1);
        idle(2);
        checkDrained("gaps");

        $display("[TB] flush during drain");
        doneCycles.delete();
        for (int i = 0; i < 8; i++) sendWord(BITS'(64'h81 + i), waited);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush cycle shift_en", 64'(shift_en), 1);
        checkOutput("flush cycle in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("post-flush shift_en", 64'(shift_en), 0);
        checkOutput("post-flush wr_en", 64'(wr_en), 0);
        checkOutput("post-flush busy", 64'(busy), 0);
        checkOutput("post-flush in_ready", 64'(in_ready), 1);
        checkOutput("post-flush no done", 64'(doneCycles.size()), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) sendWord(BITS'(64'h91 + i), waited);
        in_valid = 1'b0;
        waitDoneCount(1);
        idle(2);
        checkDrained("flush");

        $display("[TB] async reset during load");
        doneCycles.delete();
        for (int i = 0; i < 8; i++) sendWord(BITS'(64'h201 + i), waited);
        in_valid = 1'b0;
        #2;
        checkOutput("pre-reset wr_en", 64'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset wr_en", 64'(wr_en), 0);
        checkOutput("async reset busy", 64'(busy), 0);
        checkOutput("async reset in_ready", 64'(in_ready), 1);
        checkOutput("async reset out_array", 64'(out_array != '0), 0);
        shiftMark = shiftTotal;
        doneMark  = doneCycles.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        checkOutput("post-reset shifts", 64'(shiftTotal - shiftMark), 0);
        checkOutput("post-reset done", 64'(doneCycles.size() - doneMark), 0);
        checkOutput("post-reset busy", 64'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
